// File: rtl/ptr_reg_sequencer.sv
// ---------------------------------------------------------------------------
// ptr_reg_sequencer
//
// Purpose: accepts LOAD / INC / DEC / READ requests from two requesters and
// sequences them onto an external pointer register, which updates on the
// falling clock edge. Each operation step is a STAGE/COMMIT pair. The block
// reports completion with a done pulse and the pointer value captured at
// that point.
//
// Configuration macro: PTR_SEQ_ROUND_ROBIN_EN
//   defined   - simultaneous requests are resolved round-robin
//               (the requester not granted last wins)
//   undefined - fixed priority, requester 0 wins ties
//
// Ports:
//   clk                  system clock, rising-edge state updates
//   rst                  synchronous active-high reset
//   req0/req1            operation requests
//   op0/op1              opcode 00 LOAD, 01 INC, 10 DEC, 11 READ
//   opnd0/opnd1          LOAD value
//   cnt0/cnt1            INC/DEC step count (0 is treated as 1)
//   gnt0/gnt1            one-cycle grant pulse
//   done0/done1          one-cycle completion pulse
//   rdata                pointer value captured on completion
//   busy                 high whenever the sequencer is not idle
//   reg_en .. reg_swp2   pointer-register controls
//   reg_bus              load value driven to the pointer register
//   reg_data             current pointer-register value
// ---------------------------------------------------------------------------
module ptr_reg_sequencer #(
  parameter int WIDTH = 18,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] opnd0,
  input  logic [WIDTH-1:0] opnd1,
  input  logic [CNT_W-1:0] cnt0,
  input  logic [CNT_W-1:0] cnt1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             reg_en,
  output logic             reg_inc,
  output logic             reg_dec,
  output logic             reg_swp1,
  output logic             reg_swp2,
  output logic [WIDTH-1:0] reg_bus,
  input  logic [WIDTH-1:0] reg_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STAGE  = 2'd1,
    S_COMMIT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] opnd_q;
  logic [CNT_W-1:0] remaining;
  logic             owner;      // 0: requester 0 owns the operation, 1: requester 1

  logic             pick1;      // arbitration result: 1 selects requester 1
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_opnd;
  logic [CNT_W-1:0] sel_cnt;
  logic [CNT_W-1:0] start_cnt;

`ifdef PTR_SEQ_ROUND_ROBIN_EN
  logic             last_gnt;   // requester granted most recently

  // Round-robin arbitration: on a tie the requester not granted last wins.
  always_comb begin
    if (req0 && req1) begin
      pick1 = ~last_gnt;
    end else begin
      pick1 = req1;
    end
  end
`else
  // Fixed-priority arbitration: requester 0 always wins a tie.
  always_comb begin
    if (req0) begin
      pick1 = 1'b0;
    end else begin
      pick1 = req1;
    end
  end
`endif

  // Select the winning requester's operation and compute the step count.
  // LOAD is always a single step; a zero count still performs one step.
  always_comb begin
    if (pick1) begin
      sel_op   = op1;
      sel_opnd = opnd1;
      sel_cnt  = cnt1;
    end else begin
      sel_op   = op0;
      sel_opnd = opnd0;
      sel_cnt  = cnt0;
    end
    if (sel_op == OP_LOAD) begin
      start_cnt = CNT_ONE;
    end else if (sel_cnt == CNT_ZERO) begin
      start_cnt = CNT_ONE;
    end else begin
      start_cnt = sel_cnt;
    end
  end

  // Sequencer FSM with registered grant, done and read-data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= OP_LOAD;
      opnd_q    <= '0;
      remaining <= CNT_ZERO;
      owner     <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rdata     <= '0;
`ifdef PTR_SEQ_ROUND_ROBIN_EN
      last_gnt  <= 1'b1;
`endif
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            owner     <= pick1;
            op_q      <= sel_op;
            opnd_q    <= sel_opnd;
            remaining <= start_cnt;
            gnt0      <= ~pick1;
            gnt1      <= pick1;
`ifdef PTR_SEQ_ROUND_ROBIN_EN
            last_gnt  <= pick1;
`endif
            // READ completes in the grant cycle, so capture the pointer now.
            if (sel_op == OP_READ) begin
              state <= S_DONE;
              done0 <= ~pick1;
              done1 <= pick1;
              rdata <= reg_data;
            end else begin
              state <= S_STAGE;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_STAGE: begin
          state <= S_COMMIT;
        end
        S_COMMIT: begin
          remaining <= remaining - CNT_ONE;
          if (remaining > CNT_ONE) begin
            state <= S_STAGE;
          end else begin
            // The register updated on the falling edge during STAGE, so
            // reg_data already holds the final pointer value here.
            state <= S_DONE;
            done0 <= ~owner;
            done1 <= owner;
            rdata <= reg_data;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Pointer-register controls decoded from state and the latched operation.
  always_comb begin
    reg_en   = 1'b0;
    reg_inc  = 1'b0;
    reg_dec  = 1'b0;
    reg_swp1 = 1'b0;
    reg_swp2 = 1'b0;
    reg_bus  = '0;
    busy     = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_STAGE: begin
        reg_en   = 1'b1;
        reg_swp1 = 1'b1;
        reg_inc  = (op_q == OP_INC);
        reg_dec  = (op_q == OP_DEC);
        if (op_q == OP_LOAD) begin
          reg_bus = opnd_q;
        end else begin
          reg_bus = '0;
        end
      end
      S_COMMIT: begin
        reg_en = 1'b1;
      end
      S_DONE: begin
        reg_en = 1'b0;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ptr_reg_sequencer.sv
module tb_ptr_reg_sequencer;

  localparam int WIDTH = 18;
  localparam int CNT_W = 4;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [1:0]       op0, op1;
  logic [WIDTH-1:0] opnd0, opnd1;
  logic [CNT_W-1:0] cnt0, cnt1;
  logic             gnt0, gnt1, done0, done1, busy;
  logic [WIDTH-1:0] rdata;
  logic             reg_en, reg_inc, reg_dec, reg_swp1, reg_swp2;
  logic [WIDTH-1:0] reg_bus;
  logic [WIDTH-1:0] ptr;
  logic             swp2_seen = 1'b0;

  int checks = 0;
  int errors = 0;

  ptr_reg_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .opnd0(opnd0), .opnd1(opnd1), .cnt0(cnt0), .cnt1(cnt1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .busy(busy),
    .reg_en(reg_en), .reg_inc(reg_inc), .reg_dec(reg_dec),
    .reg_swp1(reg_swp1), .reg_swp2(reg_swp2), .reg_bus(reg_bus),
    .reg_data(ptr)
  );

  always #5 clk = ~clk;

  // Pointer-register model: acts on the staged strobe at the falling edge.
  always @(negedge clk) begin
    if (reg_en && reg_swp1) begin
      if (reg_inc) ptr = ptr + 18'd1;
      else if (reg_dec) ptr = ptr - 18'd1;
      else ptr = reg_bus;
    end
    if (reg_swp2) swp2_seen = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request, then observe until its done pulse (bounded).
  task automatic run_op(input logic who, input logic [1:0] op, input logic [WIDTH-1:0] opnd,
                        input logic [CNT_W-1:0] cnt, output int lat, output int stages,
                        output int incs, output int decs, output int ens,
                        output logic gnt_seen, output logic got, output logic [WIDTH-1:0] rd);
    lat = 0; stages = 0; incs = 0; decs = 0; ens = 0; got = 1'b0; rd = '0;
    if (who) begin req1 = 1'b1; op1 = op; opnd1 = opnd; cnt1 = cnt; end
    else begin req0 = 1'b1; op0 = op; opnd0 = opnd; cnt0 = cnt; end
    step();
    gnt_seen = who ? gnt1 : gnt0;
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      lat = i;
      if (reg_en && reg_swp1) stages++;
      if (reg_inc) incs++;
      if (reg_dec) decs++;
      if (reg_en) ens++;
      if ((who && done1) || (!who && done0)) begin
        got = 1'b1; rd = rdata;
        break;
      end
      step();
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    rst = 1'b0;
    checks++; if ({busy, gnt0, gnt1, done0, done1} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, gnt0, gnt1, done0, done1}); end
    checks++; if ({reg_en, reg_inc, reg_dec, reg_swp1, reg_swp2} !== 5'b0) begin errors++; $display("FAIL reset_reg: got %b expected 00000", {reg_en, reg_inc, reg_dec, reg_swp1, reg_swp2}); end
    checks++; if (rdata !== 18'h0 || reg_bus !== 18'h0) begin errors++; $display("FAIL reset_data: rdata %h reg_bus %h expected 0", rdata, reg_bus); end
  endtask

  task automatic test_load();
    ptr = 18'h0;
    req0 = 1'b1; op0 = OP_LOAD; opnd0 = 18'h00123; cnt0 = 4'd0;
    step();
    req0 = 1'b0;
    checks++; if ({gnt0, gnt1, busy} !== 3'b101) begin errors++; $display("FAIL load_gnt: got %b expected 101", {gnt0, gnt1, busy}); end
    checks++; if ({reg_en, reg_swp1, reg_swp2, reg_inc, reg_dec} !== 5'b11000 || reg_bus !== 18'h00123) begin errors++; $display("FAIL load_stage: got %b bus %h expected 11000 bus 00123", {reg_en, reg_swp1, reg_swp2, reg_inc, reg_dec}, reg_bus); end
    step();
    checks++; if ({reg_en, reg_swp1, reg_inc, reg_dec, done0, gnt0} !== 6'b100000 || reg_bus !== 18'h0) begin errors++; $display("FAIL load_commit: got %b bus %h expected 100000 bus 0", {reg_en, reg_swp1, reg_inc, reg_dec, done0, gnt0}, reg_bus); end
    step();
    checks++; if ({done0, done1, reg_en, busy} !== 4'b1001 || rdata !== 18'h00123) begin errors++; $display("FAIL load_done: got %b rdata %h expected 1001 rdata 00123", {done0, done1, reg_en, busy}, rdata); end
    step();
    checks++; if ({done0, busy} !== 2'b00 || rdata !== 18'h00123) begin errors++; $display("FAIL load_hold: got %b rdata %h expected 00 rdata 00123", {done0, busy}, rdata); end
  endtask

  task automatic test_inc_wrap();
    int lat, st, inc, dec, en; logic g, got; logic [WIDTH-1:0] rd;
    ptr = 18'h3FFFF;
    run_op(1'b1, OP_INC, 18'h0, 4'd1, lat, st, inc, dec, en, g, got, rd);
    checks++; if (!g || !got || lat != 3 || st != 1 || inc != 1 || dec != 0) begin errors++; $display("FAIL inc_wrap_seq: gnt %b done %b lat %0d stages %0d inc %0d dec %0d expected 1 1 3 1 1 0", g, got, lat, st, inc, dec); end
    checks++; if (rd !== 18'h00000) begin errors++; $display("FAIL inc_wrap_rdata: got %h expected 00000", rd); end
  endtask

  task automatic test_dec_multi();
    int lat, st, inc, dec, en; logic g, got; logic [WIDTH-1:0] rd;
    ptr = 18'h00010;
    run_op(1'b0, OP_DEC, 18'h0, 4'd3, lat, st, inc, dec, en, g, got, rd);
    checks++; if (!g || !got || lat != 7 || st != 3 || dec != 3 || inc != 0 || en != 6) begin errors++; $display("FAIL dec3_seq: gnt %b done %b lat %0d stages %0d dec %0d inc %0d en %0d expected 1 1 7 3 3 0 6", g, got, lat, st, dec, inc, en); end
    checks++; if (rd !== 18'h0000D) begin errors++; $display("FAIL dec3_rdata: got %h expected 0000d", rd); end
  endtask

  task automatic test_count_edges();
    int lat, st, inc, dec, en; logic g, got; logic [WIDTH-1:0] rd;
    ptr = 18'h00100;
    run_op(1'b1, OP_INC, 18'h0, 4'd0, lat, st, inc, dec, en, g, got, rd);
    checks++; if (!got || lat != 3 || st != 1 || rd !== 18'h00101) begin errors++; $display("FAIL cnt_zero: done %b lat %0d stages %0d rdata %h expected 1 3 1 00101", got, lat, st, rd); end
    run_op(1'b0, OP_LOAD, 18'h2AAAA, 4'd5, lat, st, inc, dec, en, g, got, rd);
    checks++; if (!got || lat != 3 || st != 1 || rd !== 18'h2AAAA) begin errors++; $display("FAIL load_cnt_forced: done %b lat %0d stages %0d rdata %h expected 1 3 1 2aaaa", got, lat, st, rd); end
    ptr = 18'h00000;
    run_op(1'b0, OP_DEC, 18'h0, 4'd15, lat, st, inc, dec, en, g, got, rd);
    checks++; if (!got || lat != 31 || st != 15 || rd !== 18'h3FFF1) begin errors++; $display("FAIL dec_max_wrap: done %b lat %0d stages %0d rdata %h expected 1 31 15 3fff1", got, lat, st, rd); end
  endtask

  task automatic test_read();
    int lat, st, inc, dec, en; logic g, got; logic [WIDTH-1:0] rd;
    ptr = 18'h10007;
    run_op(1'b1, OP_READ, 18'h0, 4'd0, lat, st, inc, dec, en, g, got, rd);
    checks++; if (!g || !got || lat != 1 || en != 0) begin errors++; $display("FAIL read_seq: gnt %b done %b lat %0d en %0d expected 1 1 1 0", g, got, lat, en); end
    checks++; if (rd !== 18'h10007) begin errors++; $display("FAIL read_rdata: got %h expected 10007", rd); end
  endtask

  task automatic test_arbitration();
    logic [2:0] seq = 3'b000;
    int cyc [3];
    int n = 0;
    logic [2:0] exp_seq;
`ifdef PTR_SEQ_ROUND_ROBIN_EN
    exp_seq = 3'b010;   // bit i is the requester of grant i: 0,1,0
`else
    exp_seq = 3'b000;
`endif
    rst = 1'b1; step(); rst = 1'b0;
    req0 = 1'b1; op0 = OP_INC; cnt0 = 4'd1;
    req1 = 1'b1; op1 = OP_INC; cnt1 = 4'd1;
    for (int i = 0; i < 40 && n < 3; i++) begin
      step();
      if (gnt0 || gnt1) begin
        seq[n] = gnt1;
        cyc[n] = i;
        n++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++; if (n != 3) begin errors++; $display("FAIL arb_timeout: grants %0d expected 3", n); end
    checks++; if (seq !== exp_seq) begin errors++; $display("FAIL arb_order: got %b expected %b", seq, exp_seq); end
    checks++; if (n == 3 && (cyc[1] - cyc[0] != 4 || cyc[2] - cyc[1] != 4)) begin errors++; $display("FAIL arb_regrant_gap: got %0d %0d expected 4 4", cyc[1] - cyc[0], cyc[2] - cyc[1]); end
    for (int i = 0; i < 10 && busy; i++) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arb_drain: busy %b expected 0", busy); end
  endtask

  task automatic test_rst_mid();
    int dones = 0;
    int strobes = 0;
    ptr = 18'h00020;
    req0 = 1'b1; op0 = OP_DEC; cnt0 = 4'd4;
    step();
    req0 = 1'b0;
    step();
    checks++; if ({reg_en, reg_swp1} !== 2'b10) begin errors++; $display("FAIL rst_mid_commit: got %b expected 10", {reg_en, reg_swp1}); end
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if ({busy, done0, reg_en, reg_inc, reg_dec, reg_swp1} !== 6'b0) begin errors++; $display("FAIL rst_mid_abort: got %b expected 000000", {busy, done0, reg_en, reg_inc, reg_dec, reg_swp1}); end
    for (int i = 0; i < 10; i++) begin
      if (done0 || done1) dones++;
      if (reg_en) strobes++;
      step();
    end
    checks++; if (dones != 0 || strobes != 0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet: dones %0d strobes %0d busy %b expected 0 0 0", dones, strobes, busy); end
  endtask

  task automatic test_swp2();
    checks++; if (swp2_seen !== 1'b0) begin errors++; $display("FAIL swp2_never: got %b expected 0", swp2_seen); end
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    op0 = OP_LOAD; op1 = OP_LOAD; opnd0 = '0; opnd1 = '0; cnt0 = '0; cnt1 = '0;
    ptr = '0;
    test_reset();
    test_load();
    test_inc_wrap();
    test_dec_multi();
    test_count_edges();
    test_read();
    test_arbitration();
    test_rst_mid();
    test_swp2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ptr_reg_sequencer.md
PTR_REG_SEQUENCER -- requirements
Module: ptr_reg_sequencer

Interface
REQ-001 Parameter WIDTH, default 18, pointer/operand width.
REQ-002 Parameter CNT_W, default 4, width of repeat-count field.
REQ-003 clk  input  1  system clock; all block state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0, req1  input  1 each  operation request from requester 0 / 1.
REQ-006 op0, op1  input  2 each  opcode: 00 LOAD, 01 INC, 10 DEC, 11 READ.
REQ-007 opnd0, opnd1  input  WIDTH each  LOAD value.
REQ-008 cnt0, cnt1  input  CNT_W each  step count for INC/DEC.
REQ-009 gnt0, gnt1  output  1 each  one-cycle grant pulse.
REQ-010 done0, done1  output  1 each  one-cycle completion pulse.
REQ-011 rdata  output  WIDTH  pointer value captured at completion.
REQ-012 busy  output  1  high in every non-IDLE state.
REQ-013 reg_en, reg_inc, reg_dec, reg_swp1, reg_swp2  output  1 each  pointer-register controls.
REQ-014 reg_bus  output  WIDTH  load value to pointer register.
REQ-015 reg_data  input  WIDTH  pointer-register current value; register updates on falling clk edge.

Function
REQ-016 States IDLE, STAGE, COMMIT, DONE; register outputs are combinational decodes of state and latched operation.
REQ-017 IDLE: on sampled req0|req1, arbitration picks one winner; op, opnd and cnt are latched; remaining = cnt, with cnt=0 treated as 1 and LOAD forced to 1.
REQ-018 gnt of the winner pulses high in the first cycle after acceptance, concurrent with the first STAGE (or DONE for READ).
REQ-019 READ: IDLE -> DONE directly; no reg_* strobe asserted.
REQ-020 STAGE: reg_en=1, reg_swp1=1, reg_swp2=0, reg_inc=(op==INC), reg_dec=(op==DEC), reg_bus=opnd for LOAD else 0; next COMMIT.
REQ-021 COMMIT: reg_en=1, reg_swp1=0, reg_swp2=0, reg_inc=0, reg_dec=0; remaining decrements; remaining>1 before decrement -> STAGE, else DONE.
REQ-022 DONE: done of the owning requester pulses; rdata <= reg_data; next IDLE.
REQ-023 Latency: LOAD/READ-independent formula: single step = 3 cycles grant-to-done inclusive, N-step INC/DEC = 2N+1 cycles, READ = 1 cycle.
REQ-024 reg_swp2 is never asserted; all reg_* are 0 in IDLE and DONE.
REQ-025 Requests are not queued; a request present while busy is evaluated only on return to IDLE; a request dropped before gnt is lost.
REQ-026 Earliest re-grant: cycle after DONE (IDLE sampled once).
REQ-027 Pointer wrap (3FFFF+1 -> 0, 0-1 -> 3FFFF) is left to the register; no bounds checking or stall.
REQ-028 rdata holds its value until the next DONE.

Reset
REQ-029 rst forces IDLE; gnt*, done*, busy, all reg_* and reg_bus = 0; rdata = 0; remaining = 0.
REQ-030 rst mid-operation aborts the operation: no done pulse, no further reg_* strobes from the next cycle; pointer register handled by its own reset.
REQ-031 Round-robin last-grant pointer resets to requester 1 (requester 0 wins first tie).

Configuration
REQ-032 Macro PTR_SEQ_ROUND_ROBIN_EN defined: on simultaneous req0 and req1, the requester not granted last wins; pointer updates on each grant.
REQ-033 Macro undefined: fixed priority, requester 0 always wins ties; no last-grant state.

Verification
REQ-034 After rst, req0 LOAD opnd=0x00123 -> gnt0 next cycle, STAGE reg_bus=0x00123 swp1=1, COMMIT, done0 with rdata=0x00123 three cycles after gnt0.
REQ-035 reg_data=0x3FFFF, req1 INC cnt=1 -> one STAGE with reg_inc=1, done1 with rdata=0x00000.
REQ-036 req0 DEC cnt=3 from 0x00010 -> three STAGE/COMMIT pairs, done0 at cycle 7 after grant, rdata=0x0000D.
REQ-037 req0 and req1 held together, INC cnt=1 each -> with macro grants alternate 0,1,0; without macro requester 0 always granted while held.
REQ-038 rst asserted during COMMIT of DEC cnt=4 -> next cycle IDLE, busy=0, no done0, all reg_* 0.
REQ-039 req1 READ with reg_data=0x10007 -> gnt1 and done1 in the same cycle, rdata=0x10007, no reg_en pulse.
